instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end fetch stage that sits directly upstream of the control-unit `pipeline` block. It reads instruction bytes from an 8-bit memory port and assembles them into 24-bit instructions. Assembled instructions are buffered in a small prefetch FIFO and presented to `pipeline` on its `next_instruction` / `next_instruction_available` / `ready_for_next_instruction` handshake. A jump request flushes all buffered and partially assembled instructions and restarts fetching at the target address.

## Interface
- `ADDR_WIDTH`, default 16: byte-address width of the memory port and program counter.
- `FIFO_DEPTH`, default 4: prefetch FIFO entries. Power of two, at least 2.
- `RESET_PC`, default 0: fetch address after reset.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_address` out ADDR_WIDTH: byte address of the current read request.
- `mem_read` out 1: read request is valid.
- `mem_data` in 8: read data.
- `mem_ready` in 1: `mem_data` is valid for the current request. The byte is accepted at the edge where `mem_read & mem_ready` is high.
- `jump_valid` in 1: redirect fetch. Single-cycle pulse or held; each cycle it is high is a flush.
- `jump_target` in ADDR_WIDTH: new fetch address, sampled when `jump_valid` is high.
- `next_instruction` out 24: FIFO head instruction.
- `next_instruction_available` out 1: FIFO head is valid.
- `ready_for_next_instruction` in 1: from `pipeline`. The head is consumed at the edge where available & ready.
- `instruction_address` out ADDR_WIDTH: byte address of the first byte of the head instruction.

## Operation
- **Byte assembly.** Each instruction is 3 consecutive bytes, big-endian:
  - first byte goes to bits [23:16];
  - second byte goes to [15:8];
  - third byte goes to [7:0].
- **Registered state:**
  - `fetch_pc` (ADDR_WIDTH);
  - `byte_index` (0..2);
  - a 16-bit partial-instruction register;
  - `start_pc`, the address of byte 0 of the instruction being assembled.
- **Address generation.** `mem_address = fetch_pc`. Each accepted byte increments `fetch_pc` by 1, wrapping modulo 2^ADDR_WIDTH.
- **Assembly FSM:**
  - BYTE0 → BYTE1 → BYTE2 → BYTE0, one transition per accepted byte.
  - On BYTE2 acceptance, {partial, mem_data} and `start_pc` are pushed into the FIFO.
  - With no accepted byte, the state holds.
- **Request rule.** `mem_read = !reset & (count < FIFO_DEPTH)`, where `count` is the registered FIFO occupancy. Fetch of a new instruction cannot start when the FIFO is full, so a push never overflows.
- **FIFO:**
  - Entries are {instruction[23:0], address}.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally; occupancy is tracked separately from the pointers.
  - Push and pop at the same edge leave `count` unchanged.
  - Pop from empty is impossible, because available is low when empty.
- **Outputs.** `next_instruction_available = (count != 0) & !jump_valid`. `next_instruction` and `instruction_address` are driven from the head entry. When the FIFO is empty they are 0.
- **Jump (highest priority):** at an edge with `jump_valid` high:
  - the FIFO is emptied (`count = 0`, pointers reset);
  - `byte_index` returns to BYTE0;
  - `fetch_pc` and `start_pc` take `jump_target`;
  - any byte accepted at that edge is discarded;
  - no pop occurs at that edge, because available is forced low.
- **Reset, asserted at any time including mid-instruction:**
  - `fetch_pc = start_pc = RESET_PC`;
  - `byte_index = 0`;
  - FIFO empty;
  - partial register cleared.

## Timing
- **Output values during and after reset:**
  - `mem_read = 0`;
  - `mem_address = RESET_PC`;
  - `next_instruction_available = 0`;
  - `next_instruction = 0`;
  - `instruction_address = 0`.
- **After reset deasserts:** `mem_read` goes to 1 combinationally.
- **Latency.** With `mem_ready` tied high, bytes are accepted at edges 1, 2 and 3. `next_instruction_available` rises after edge 3.
- **Throughput.** Peak is one instruction per 3 cycles.
- **Wait states.** Each cycle with `mem_ready` low while `mem_read` is high adds one cycle. Address and state hold.
- **FIFO full.** `mem_read` drops after the edge that makes `count == FIFO_DEPTH`. It returns the cycle after the first pop.
- **Jump.** `mem_address = jump_target` in the cycle after the jump edge. The first post-jump instruction is available no earlier than 3 accepted bytes later.
- **Combinational paths:**
  - `next_instruction_available` depends combinationally on `jump_valid`;
  - no output depends combinationally on `mem_data`, `mem_ready` or `ready_for_next_instruction`.

## Test plan
- **Basic fetch.** Reset with memory = 0x12,0x34,0x56,0xAB,0xCD,0xEF and `mem_ready` = 1.
  - First instruction 0x123456 with `instruction_address` 0, available after 3 edges.
  - Next instruction 0xABCDEF with address 3.
- **Backpressure/full.** Hold `ready_for_next_instruction` = 0.
  - After 12 accepted bytes: `count` = 4 and `mem_read` = 0; `mem_address` stays 12.
  - Assert ready for one cycle: exactly one pop, then `mem_read` = 1.
- **Wait states.** Hold `mem_ready` low on alternate cycles.
  - Instruction bytes and addresses are unchanged.
  - Each instruction takes 6 cycles.
- **Mid-instruction jump.** Pulse `jump_valid` with target 0x0100 after 1 byte accepted, with 2 instructions queued.
  - `next_instruction_available` is 0 in the jump cycle.
  - The FIFO empties.
  - Next head is assembled from bytes 0x0100..0x0102 with address 0x0100.
- **Simultaneous events.**
  - Push and pop at the same edge with `count` = 2: `count` stays 2.
  - Jump at the same edge as a BYTE2 acceptance: the assembled instruction is discarded.
- **Wrap and reset.**
  - `ADDR_WIDTH` = 16, jump to 0xFFFE: the instruction is assembled from 0xFFFE, 0xFFFF, 0x0000, and the next one fetches from 0x0001.
  - Asynchronous reset mid-byte: all outputs return to their reset values immediately, and the first post-reset instruction comes from `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: pulls bytes from an 8-bit memory port and packs them into 24-bit big-endian
// instructions, which are queued in a small prefetch FIFO ahead of the pipeline.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ready,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [23:0]           next_instruction,
  output logic                  next_instruction_available,
  input  logic                  ready_for_next_instruction,
  output logic [ADDR_WIDTH-1:0] instruction_address
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} byte_state_t;

  byte_state_t           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] start_pc_reg, start_pc_next;
  logic [15:0]           partial_reg, partial_next;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [23:0]           instr_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic                  accept, push, pop, fifo_empty;

  assign fifo_empty  = (count_reg == '0);
  assign mem_read    = !reset && (count_reg < FULL_COUNT);
  assign mem_address = fetch_pc_reg;
  assign accept      = mem_read && mem_ready;

  // A jump in flight hides the head so the pipeline never consumes a stale instruction.
  assign next_instruction_available = !fifo_empty && !jump_valid;
  assign pop                 = next_instruction_available && ready_for_next_instruction;
  assign next_instruction    = fifo_empty ? '0 : instr_mem[rd_ptr_reg];
  assign instruction_address = fifo_empty ? '0 : addr_mem[rd_ptr_reg];

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    start_pc_next = start_pc_reg;
    partial_next  = partial_reg;
    push          = 1'b0;
    if (jump_valid) begin
      state_next    = BYTE0;
      fetch_pc_next = jump_target;
      start_pc_next = jump_target;
    end else if (accept) begin
      fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(1);
      unique case (state_reg)
        BYTE0: begin
          partial_next[15:8] = mem_data;
          state_next         = BYTE1;
        end
        BYTE1: begin
          partial_next[7:0] = mem_data;
          state_next        = BYTE2;
        end
        BYTE2: begin
          push          = 1'b1;
          state_next    = BYTE0;
          start_pc_next = fetch_pc_reg + ADDR_WIDTH'(1);
        end
        default: state_next = BYTE0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BYTE0;
      fetch_pc_reg <= RESET_PC;
      start_pc_reg <= RESET_PC;
      partial_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      start_pc_reg <= start_pc_next;
      partial_reg  <= partial_next;
      if (jump_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
        else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= {partial_reg, mem_data};
      addr_mem[wr_ptr_reg]  <= start_pc_reg;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations plus a long
// randomized run, all outputs compared every cycle against a queue-based reference model.
module tb_instruction_fetch;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic        mem_ready = 1'b1;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic [23:0] next_instruction;
  logic        next_instruction_available;
  logic        ready_for_next_instruction = 1'b0;
  logic [15:0] instruction_address;

  logic [7:0] mem [0:65535];
  assign mem_data = mem[mem_address];

  instruction_fetch #(.ADDR_WIDTH(16), .FIFO_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .jump_valid(jump_valid),
    .jump_target(jump_target),
    .next_instruction(next_instruction),
    .next_instruction_available(next_instruction_available),
    .ready_for_next_instruction(ready_for_next_instruction),
    .instruction_address(instruction_address)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: fetch address, bytes gathered so far, and a queue of finished instructions.
  typedef struct {
    logic [23:0] instr;
    logic [15:0] addr;
  } entry_t;

  entry_t      m_fifo[$];
  logic [7:0]  m_bytes[$];
  logic [15:0] m_pc = RESET_PC;
  logic [15:0] m_start = RESET_PC;
  bit          m_acc, m_pop;
  entry_t      m_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fifo.delete();
      m_bytes.delete();
      m_pc    = RESET_PC;
      m_start = RESET_PC;
    end else begin
      m_acc = (m_fifo.size() < DEPTH) && mem_ready;
      m_pop = (m_fifo.size() != 0) && !jump_valid && ready_for_next_instruction;
      if (jump_valid) begin
        m_fifo.delete();
        m_bytes.delete();
        m_pc    = jump_target;
        m_start = jump_target;
      end else begin
        if (m_pop) void'(m_fifo.pop_front());
        if (m_acc) begin
          if (m_bytes.size() == 0) m_start = m_pc;
          m_bytes.push_back(mem[m_pc]);
          m_pc = m_pc + 16'd1;
          if (m_bytes.size() == 3) begin
            m_e.instr = {m_bytes[0], m_bytes[1], m_bytes[2]};
            m_e.addr  = m_start;
            m_fifo.push_back(m_e);
            m_bytes.delete();
          end
        end
      end
    end
  end

  logic        e_read, e_avail;
  logic [23:0] e_instr;
  logic [15:0] e_iaddr;

  always @(negedge clk) begin
    e_read  = !reset && (m_fifo.size() < DEPTH);
    e_avail = (m_fifo.size() != 0) && !jump_valid;
    e_instr = (m_fifo.size() != 0) ? m_fifo[0].instr : 24'h0;
    e_iaddr = (m_fifo.size() != 0) ? m_fifo[0].addr : 16'h0;
    check("model_mem_read", 32'(mem_read), 32'(e_read));
    check("model_mem_address", 32'(mem_address), 32'(m_pc));
    check("model_available", 32'(next_instruction_available), 32'(e_avail));
    check("model_instruction", 32'(next_instruction), 32'(e_instr));
    check("model_instr_address", 32'(instruction_address), 32'(e_iaddr));
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'hAB; mem[4] = 8'hCD; mem[5] = 8'hEF;
    mem[16'h0100] = 8'hA1; mem[16'h0101] = 8'hB2; mem[16'h0102] = 8'hC3;
    mem[16'hFFFE] = 8'h9A; mem[16'hFFFF] = 8'hBC;

    // Reset values and basic fetch
    step(2);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'(RESET_PC));
    check("rst_available", 32'(next_instruction_available), 32'd0);
    check("rst_instruction", 32'(next_instruction), 32'd0);
    check("rst_instr_address", 32'(instruction_address), 32'd0);
    reset = 1'b0;
    #1 check("post_rst_mem_read", 32'(mem_read), 32'd1);
    step(2);
    check("lat_not_yet", 32'(next_instruction_available), 32'd0);
    step(1);
    check("lat_available", 32'(next_instruction_available), 32'd1);
    check("first_instr", 32'(next_instruction), 32'h123456);
    check("first_addr", 32'(instruction_address), 32'h0);

    // Backpressure until full
    step(9);
    check("full_mem_read", 32'(mem_read), 32'd0);
    check("full_mem_address", 32'(mem_address), 32'd12);
    step(2);
    check("full_hold_address", 32'(mem_address), 32'd12);
    check("full_head_kept", 32'(next_instruction), 32'h123456);
    ready_for_next_instruction = 1'b1;
    step(1);
    ready_for_next_instruction = 1'b0;
    check("pop_mem_read", 32'(mem_read), 32'd1);
    check("pop_second_instr", 32'(next_instruction), 32'hABCDEF);
    check("pop_second_addr", 32'(instruction_address), 32'h3);
    step(1);
    check("single_pop_instr", 32'(next_instruction), 32'hABCDEF);
    check("refetch_address", 32'(mem_address), 32'd13);

    // Mid-instruction jump with two queued
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(7);
    jump_valid = 1'b1;
    jump_target = 16'h0100;
    #1 check("jump_avail_low", 32'(next_instruction_available), 32'd0);
    step(1);
    jump_valid = 1'b0;
    #1;
    check("jump_address", 32'(mem_address), 32'h0100);
    check("jump_flushed", 32'(next_instruction_available), 32'd0);
    step(2);
    check("jump_not_yet", 32'(next_instruction_available), 32'd0);
    step(1);
    check("jump_instr", 32'(next_instruction), 32'hA1B2C3);
    check("jump_instr_addr", 32'(instruction_address), 32'h0100);

    // Address wrap
    jump_valid = 1'b1;
    jump_target = 16'hFFFE;
    step(1);
    jump_valid = 1'b0;
    step(3);
    check("wrap_instr", 32'(next_instruction), 32'h9ABC12);
    check("wrap_instr_addr", 32'(instruction_address), 32'hFFFE);
    check("wrap_next_fetch", 32'(mem_address), 32'h0001);

    // Alternate-cycle wait states: one instruction per 6 cycles
    reset = 1'b1;
    ready_for_next_instruction = 1'b1;
    mem_ready = 1'b0;
    step(1);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      mem_ready = ~mem_ready;
      if (i == 5 || i == 11) check("wait_not_yet", 32'(next_instruction_available), 32'd0);
      if (i == 6) check("wait_instr0", 32'(next_instruction), 32'h123456);
      if (i == 12) begin
        check("wait_instr1", 32'(next_instruction), 32'hABCDEF);
        check("wait_instr1_addr", 32'(instruction_address), 32'h3);
      end
    end

    // Asynchronous reset mid-instruction
    mem_ready = 1'b1;
    ready_for_next_instruction = 1'b0;
    step(1);
    #2 reset = 1'b1;
    #1;
    check("arst_mem_read", 32'(mem_read), 32'd0);
    check("arst_mem_address", 32'(mem_address), 32'(RESET_PC));
    check("arst_available", 32'(next_instruction_available), 32'd0);
    check("arst_instruction", 32'(next_instruction), 32'd0);
    check("arst_instr_address", 32'(instruction_address), 32'd0);
    step(1);
    reset = 1'b0;
    step(3);
    check("arst_first_instr", 32'(next_instruction), 32'h123456);
    check("arst_first_addr", 32'(instruction_address), 32'(RESET_PC));

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      ready_for_next_instruction = 1'($urandom_range(0, 1));
      jump_valid = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 1) == 1) jump_target = 16'hFFFC + 16'($urandom_range(0, 7));
      else jump_target = 16'($urandom);
      if ($urandom_range(0, 400) == 0) begin
        #2 reset = 1'b1;
        step(1);
        reset = 1'b0;
      end else begin
        step(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
